data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
Parametrised data memory for the MIPS MEM stage, successor to the plain word memory. Takes byte, halfword, word and (64-bit builds) doubleword loads and stores at byte addresses, using byte-lane write enables and sign/zero extension of loads. Clears its own contents after reset with a sequencer, so no reset fan-out reaches the storage array. Reports alignment faults to the exception logic.

Parameters:
WIDTH, 32, data word width in bits; 32 or 64 only
DEPTHI, 16, word-index bits; storage holds 2^DEPTHI words
OFFB, $clog2(WIDTH/8), byte-offset bits (derived localparam, not overridable)

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  asynchronous, active-low reset
MemRead  in  1  load request, sampled at posedge
MemWrite  in  1  store request, sampled at posedge
Size  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when WIDTH=64)
Unsigned  in  1  1 = zero-extend load, 0 = sign-extend load
Address  in  WIDTH  byte address
WD  in  WIDTH  store data, right-justified (bits [8*n-1:0] for an n-byte access)
RD  out  WIDTH  load data, extended to WIDTH
Ready  out  1  one-cycle pulse: the access sampled on the previous edge has completed
Misaligned  out  1  one-cycle pulse alongside Ready: the access was illegal or unaligned
Busy  out  1  high while the post-reset clear runs

Behaviour:
- Reset, rst=0 asynchronous: RD=0, Ready=0, Misaligned=0, Busy=1, clear counter=0, state=CLEAR. Storage is not reset directly.
- CLEAR state:
  - Each posedge writes all-zero to word[counter], then counter+1.
  - On the edge that writes word 2^DEPTHI-1, go to IDLE; Busy reads 0 after that edge.
  - Clear takes 2^DEPTHI cycles.
  - Requests during CLEAR are dropped: no write, no Ready, no Misaligned.
- rst asserted mid-CLEAR or mid-access: immediate return to the reset values; the clear restarts from word 0.
- IDLE state, per-cycle pipeline:
  - A request sampled at edge n completes at edge n; Ready=1 for the cycle after edge n.
  - One request accepted every cycle; back-to-back requests give back-to-back Ready pulses.
- Address decode:
  - Word index = Address[OFFB+DEPTHI-1:OFFB]; upper address bits are ignored (wrap-around).
  - Lane = Address[OFFB-1:0].
- Alignment and legality:
  - Half needs Address[0]=0.
  - Word needs Address[1:0]=0.
  - Dword needs Address[2:0]=0 and WIDTH=64; Size=11 with WIDTH=32 is always illegal.
  - Illegal or unaligned access: no storage write, RD=0, Ready=1 and Misaligned=1 for one cycle.
- Store: only the addressed byte lanes are written, from the low bytes of WD; all other lanes are unchanged.
- Load:
  - The addressed lanes are right-justified, then sign-extended (Unsigned=0) or zero-extended (Unsigned=1) to WIDTH.
  - Full-width loads ignore Unsigned.
  - RD holds its value until the next completed load or fault.
- MemRead and MemWrite together:
  - Read-before-write: RD returns the pre-store contents and the store is committed.
  - A single Ready pulse; alignment checks apply once.
- Write-only access: Ready pulses, RD unchanged.
- No request: Ready=0, Misaligned=0.
- Same-word store at edge n then load at edge n+1: the load returns the new data (no hazard).

Decomposition:
- Package mem_pkg holds:
  - mem_size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD);
  - mem_state_t enum (CLEAR, IDLE);
  - functions for byte-enable generation and load extension.
- Sub-module mem_bytes_ram: a 2^DEPTHI x WIDTH array with a per-byte write-enable vector and a registered read port on the same clock.
- data_mem_ctrl owns the FSM, the clear counter, the alignment check and the lane steering.

Test Plan:
- Reset: rst low 3 cycles, then high, DEPTHI=4 → Busy=1 for exactly 16 cycles; a MemWrite during CLEAR is dropped; a later read of every word returns 0.
- Sub-word stores and loads: SW 0x11223344 @0x8; SB WD=0xAB @0x9; LW @0x8 → 0x1122AB44, Ready one cycle after the request; LB @0x9 → 0xFFFFFFAB; LBU @0x9 → 0x000000AB; LH @0xA → 0x00001122.
- Faults: LH @0x3 → Misaligned=1, RD=0, Ready=1; SW @0x6 → Misaligned=1 and word 0x4 unchanged; Size=11 at WIDTH=32 → Misaligned=1.
- Read-before-write: MemRead=MemWrite=1 on a word holding 0x5 with WD=0x9 → RD=0x5; the next LW → 0x9.
- Wrap-around and throughput: with DEPTHI=4, SW 0xDEADBEEF @0x40 then LW @0x0 on the next cycle → 0xDEADBEEF; 8 consecutive LWs → 8 consecutive Ready pulses.
- Reset mid-clear: assert rst at clear cycle 7 → Busy stays 1; after release the clear runs a full 16 cycles again.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and lane helpers for the data memory controller
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } mem_size_t;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } mem_state_t;

  // Lane mask for an access starting at lane 0; the caller shifts it by the byte offset.
  function automatic logic [7:0] size_mask(input mem_size_t sz);
    case (sz)
      SZ_BYTE: return 8'h01;
      SZ_HALF: return 8'h03;
      SZ_WORD: return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] d, input mem_size_t sz,
                                              input logic uns);
    case (sz)
      SZ_BYTE: return uns ? {56'b0, d[7:0]}  : {{56{d[7]}}, d[7:0]};
      SZ_HALF: return uns ? {48'b0, d[15:0]} : {{48{d[15]}}, d[15:0]};
      SZ_WORD: return uns ? {32'b0, d[31:0]} : {{32{d[31]}}, d[31:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_bytes_ram.sv
// rtl/mem_bytes_ram.sv - byte-lane writable storage array with registered read port
module mem_bytes_ram #(
  parameter int WIDTH  = 32,
  parameter int DEPTHI = 16
) (
  input  logic                 clk,
  input  logic [WIDTH/8-1:0]   we,
  input  logic                 re,
  input  logic [DEPTHI-1:0]    idx,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [2**DEPTHI];

  // Non-blocking read and write on the same edge give read-before-write.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[idx];
    for (int b = 0; b < WIDTH/8; b++) begin
      if (we[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - MEM-stage data memory: sub-word access, post-reset clear, fault report
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTHI = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [1:0]       Size,
  input  logic             Unsigned,
  input  logic [WIDTH-1:0] Address,
  input  logic [WIDTH-1:0] WD,
  output logic [WIDTH-1:0] RD,
  output logic             Ready,
  output logic             Misaligned,
  output logic             Busy
);

  localparam int OFFB = $clog2(WIDTH/8);
  localparam int NB   = WIDTH/8;

  mem_state_t        state, state_nx;
  logic [DEPTHI-1:0] clr_cnt;
  mem_size_t         sz, rd_size;
  logic [OFFB-1:0]   lane, rd_lane;
  logic              rd_uns, rd_zero;
  logic              req, legal;
  logic [7:0]        mask;
  logic [NB-1:0]     ram_we;
  logic              ram_re;
  logic [DEPTHI-1:0] ram_idx;
  logic [WIDTH-1:0]  ram_wdata, ram_rdata, shifted;
  logic [63:0]       ext;
  logic              unused_bits;

  assign sz   = mem_size_t'(Size);
  assign lane = Address[OFFB-1:0];
  assign req  = (MemRead | MemWrite) && (state == IDLE);
  assign mask = size_mask(sz);
  assign Busy = (state == CLEAR);

  always_comb begin
    case (sz)
      SZ_HALF:  legal = ~Address[0];
      SZ_WORD:  legal = (Address[1:0] == 2'b00);
      SZ_DWORD: legal = (WIDTH == 64) && (Address[2:0] == 3'b000);
      default:  legal = 1'b1;
    endcase
  end

  // Next state plus storage port steering; the clear sequencer owns the port while Busy.
  always_comb begin
    state_nx  = state;
    ram_we    = '0;
    ram_re    = 1'b0;
    ram_idx   = Address[OFFB+DEPTHI-1:OFFB];
    ram_wdata = WD << {lane, 3'b000};
    case (state)
      CLEAR: begin
        ram_we    = '1;
        ram_idx   = clr_cnt;
        ram_wdata = '0;
        if (clr_cnt == {DEPTHI{1'b1}}) state_nx = IDLE;
      end
      default: begin
        if (req && legal) begin
          ram_we = MemWrite ? (mask[NB-1:0] << lane) : '0;
          ram_re = MemRead;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= CLEAR;
    else      state <= state_nx;
  end

  // Load steering is captured with the request so RD can be formed after the RAM register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_cnt    <= '0;
      Ready      <= 1'b0;
      Misaligned <= 1'b0;
      rd_zero    <= 1'b1;
      rd_size    <= SZ_BYTE;
      rd_lane    <= '0;
      rd_uns     <= 1'b0;
    end else begin
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      Ready      <= req;
      Misaligned <= req && !legal;
      if (req && !legal) begin
        rd_zero <= 1'b1;
      end else if (req && MemRead) begin
        rd_zero <= 1'b0;
        rd_size <= sz;
        rd_lane <= lane;
        rd_uns  <= Unsigned;
      end
    end
  end

  mem_bytes_ram #(.WIDTH(WIDTH), .DEPTHI(DEPTHI)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign shifted     = ram_rdata >> {rd_lane, 3'b000};
  assign ext         = load_extend(64'(shifted), rd_size, rd_uns);
  assign RD          = rd_zero ? '0 : ext[WIDTH-1:0];
  assign unused_bits = ^{Address, ext};

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl (WIDTH=32, DEPTHI=4)
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, Unsigned = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic [31:0] Address = '0, WD = '0;
  logic [31:0] RD;
  logic        Ready, Misaligned, Busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  ref_mem [64];
  logic [31:0] exp_rd;
  logic        exp_ready, exp_mis;

  data_mem_ctrl #(.WIDTH(32), .DEPTHI(4)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .Size(Size),
    .Unsigned(Unsigned), .Address(Address), .WD(WD), .RD(RD), .Ready(Ready),
    .Misaligned(Misaligned), .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    exp_rd = '0;
  endtask

  // Byte-addressed reference: 64 bytes, little-endian, address taken modulo 64.
  task automatic model_step(input logic r, input logic w, input logic [1:0] sz,
                            input logic u, input logic [31:0] a, input logic [31:0] d);
    int n;
    logic ok;
    logic [31:0] v;
    n  = 1 << sz;
    ok = (sz != 2'b11) && ((a % n) == 0);
    exp_ready = r | w;
    exp_mis   = (r | w) && !ok;
    if ((r | w) && !ok) exp_rd = '0;
    else if (r | w) begin
      if (r) begin
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[(a + i) % 64]) << (8 * i));
        if (!u && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 1);
        exp_rd = v;
      end
      if (w) for (int i = 0; i < n; i++) ref_mem[(a + i) % 64] = d[8*i +: 8];
    end
  endtask

  task automatic access(input logic r, input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemRead = r; MemWrite = w; Size = sz; Unsigned = u; Address = a; WD = d;
    model_step(r, w, sz, u, a, d);
    @(posedge clk);
    #1;
    check("ready", {31'b0, Ready}, {31'b0, exp_ready});
    check("misaligned", {31'b0, Misaligned}, {31'b0, exp_mis});
    check("rd", RD, exp_rd);
  endtask

  task automatic idle();
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  // Counts edges until Busy falls; any request held during the clear must stay silent.
  task automatic wait_clear(output int cycles);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      check("clear_ready", {31'b0, Ready}, 32'd0);
      if (!Busy) break;
    end
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [1:0]  rsz;
    logic [31:0] ra;
    model_clear();

    #1;
    check("reset_busy", {31'b0, Busy}, 32'd1);
    check("reset_rd", RD, 32'd0);
    check("reset_ready", {31'b0, Ready}, 32'd0);
    repeat (3) @(negedge clk);
    MemWrite = 1'b1; Size = 2'b10; Address = 32'h3C; WD = 32'h12345678;
    rst = 1'b1;
    wait_clear(cyc);
    check("clear_cycles", cyc, 32'd16);
    for (int i = 0; i < 16; i++) access(1'b1, 1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0);

    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'h11223344);
    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h9, 32'hAB);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    check("lw_0x8", RD, 32'h1122AB44);
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h9, 32'h0);
    check("lb_0x9", RD, 32'hFFFFFFAB);
    access(1'b1, 1'b0, 2'b00, 1'b1, 32'h9, 32'h0);
    check("lbu_0x9", RD, 32'h000000AB);
    access(1'b1, 1'b0, 2'b01, 1'b0, 32'hA, 32'h0);
    check("lh_0xa", RD, 32'h00001122);

    access(1'b1, 1'b0, 2'b01, 1'b0, 32'h3, 32'h0);
    check("lh_0x3_mis", {31'b0, Misaligned}, 32'd1);
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'hCAFEF00D);
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h6, 32'h55555555);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    check("word4_kept", RD, 32'hCAFEF00D);
    access(1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    check("dword_mis", {31'b0, Misaligned}, 32'd1);

    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h5);
    access(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h9);
    check("rbw_old", RD, 32'h5);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("rbw_new", RD, 32'h9);

    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    check("wrap", RD, 32'hDEADBEEF);
    for (int i = 0; i < 8; i++) access(1'b1, 1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0);
    idle();
    #1;
    access(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      rsz = 2'($urandom_range(0, 3));
      ra  = $urandom;
      if ($urandom_range(0, 3) != 0) ra = ra & ~((32'h1 << rsz) - 1);
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rsz,
             1'($urandom_range(0, 1)), ra, $urandom);
    end
    idle();

    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", {31'b0, Busy}, 32'd1);
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midclear_busy", {31'b0, Busy}, 32'd1);
    check("midclear_rd", RD, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wait_clear(cyc);
    check("reclear_cycles", cyc, 32'd16);
    for (int i = 0; i < 16; i++) access(1'b1, 1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
